tff_bank_counter: RTL and testbench

Parametrised successor to the single-bit T flip-flop: a WIDTH-bit register bank that either toggles bits individually from a T vector or acts as a modulo-N up/down counter with parallel load. It sits wherever the design needs toggle registers, dividers or event counters. Complementary outputs and a terminal-count flag are provided. Behaviour is selected per cycle by a mode input.

---
 rtl/tff_bank_counter.sv | 92 +++++++++
 tb/tb_tff_bank_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tff_bank_counter.sv
// WIDTH-bit register bank: per-bit toggle, modulo-N up/down counter with
// parallel load, complementary outputs, terminal-count and wrap flags.
module tff_bank_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 2 ** WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

  // One extra bit so MODULUS = 2**WIDTH compares exactly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   END_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] END_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH:0]   q_ext;
  logic             at_end;
  logic             at_zero;
  logic             out_of_range;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  assign q_ext        = {1'b0, q};
  assign at_end       = (q_ext >= END_EXT);
  assign at_zero      = (q == '0);
  assign out_of_range = (q_ext >= MOD_EXT);

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (en) begin
      case (mode)
        MODE_TOGGLE: q_nxt = q ^ t;
        MODE_UP: begin
          if (!at_end) begin
            q_nxt = q + WIDTH'(1);
          end else if (SATURATE) begin
            q_nxt = END_VAL;
          end else begin
            q_nxt    = '0;
            wrap_nxt = 1'b1;
          end
        end
        MODE_DOWN: begin
          if (at_zero) begin
            if (!SATURATE) begin
              q_nxt    = END_VAL;
              wrap_nxt = 1'b1;
            end
          end else if (out_of_range) begin
            q_nxt = END_VAL;
          end else begin
            q_nxt = q - WIDTH'(1);
          end
        end
        MODE_LOAD: q_nxt = d;
        default:   q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

  assign qb = ~q;
  // Terminal count looks at mode and q only, so it is valid while en is low.
  assign tc = ((mode == MODE_UP) && at_end) || ((mode == MODE_DOWN) && at_zero);

endmodule

// File: tb/tb_tff_bank_counter.sv
// Bench for tff_bank_counter: three configurations driven in lockstep,
// expected state queued at drive time and compared after each edge.
module tb_tff_bank_counter;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] mode;
  logic [7:0] t, d;

  logic [7:0] q0, qb0, q1, qb1;
  logic [3:0] q2, qb2;
  logic       tc0, tc1, tc2, w0, w1, w2;

  logic [7:0] qv[3], qbv[3];
  logic       tcv[3], wv[3];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int q[3];
    bit w[3];
  } exp_t;

  exp_t sb[$];
  int   mq[3];
  int   modv[3] = '{10, 10, 16};
  bit   satv[3] = '{1'b0, 1'b1, 1'b0};
  int   mask[3] = '{255, 255, 15};

  always #5 clk = ~clk;

  tff_bank_counter #(.WIDTH(8), .MODULUS(10), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d),
    .q(q0), .qb(qb0), .tc(tc0), .wrap(w0));
  tff_bank_counter #(.WIDTH(8), .MODULUS(10), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d),
    .q(q1), .qb(qb1), .tc(tc1), .wrap(w1));
  tff_bank_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t[3:0]), .d(d[3:0]),
    .q(q2), .qb(qb2), .tc(tc2), .wrap(w2));

  assign qv[0] = q0;  assign qbv[0] = qb0;  assign tcv[0] = tc0;  assign wv[0] = w0;
  assign qv[1] = q1;  assign qbv[1] = qb1;  assign tcv[1] = tc1;  assign wv[1] = w1;
  assign qv[2] = {4'h0, q2};  assign qbv[2] = {4'h0, qb2};
  assign tcv[2] = tc2;  assign wv[2] = w2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, check tc combinationally, queue the
  // expected post-edge state, then compare it after the edge.
  task automatic step(input bit r, input bit e, input logic [1:0] m,
                      input logic [7:0] tv, input logic [7:0] dv);
    exp_t x;
    exp_t got;
    rst = r; en = e; mode = m; t = tv; d = dv;
    #1;
    for (int i = 0; i < 3; i++) begin
      bit etc;
      etc = ((m == 2'b01) && (mq[i] >= modv[i] - 1)) || ((m == 2'b10) && (mq[i] == 0));
      chk($sformatf("tc%0d", i), 32'(tcv[i]), 32'(etc));
    end
    for (int i = 0; i < 3; i++) begin
      int nq;
      bit nw;
      nq = mq[i];
      nw = 1'b0;
      if (r) nq = 0;
      else if (e) begin
        case (m)
          2'b00: nq = mq[i] ^ (int'(tv) & mask[i]);
          2'b01: begin
            if (mq[i] < modv[i] - 1) nq = mq[i] + 1;
            else if (satv[i]) nq = modv[i] - 1;
            else begin nq = 0; nw = 1'b1; end
          end
          2'b10: begin
            if (mq[i] == 0) begin
              if (!satv[i]) begin nq = modv[i] - 1; nw = 1'b1; end
            end else if (mq[i] >= modv[i]) nq = modv[i] - 1;
            else nq = mq[i] - 1;
          end
          default: nq = int'(dv) & mask[i];
        endcase
      end
      x.q[i] = nq;
      x.w[i] = nw;
      mq[i]  = nq;
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("q%0d", i), 32'(qv[i]), 32'(got.q[i]));
      chk($sformatf("qb%0d", i), 32'(qbv[i]), 32'((~got.q[i]) & mask[i]));
      chk($sformatf("wrap%0d", i), 32'(wv[i]), 32'(got.w[i]));
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; t = '0; d = '0;
    for (int i = 0; i < 3; i++) mq[i] = 0;
    @(posedge clk);
    #1;

    // Reset state, tc under mode 00 and mode 10
    step(1, 0, 2'b00, 8'h00, 8'h00);
    chk("rst_qb", 32'(qb0), 32'hFF);
    step(1, 1, 2'b10, 8'h00, 8'h00);

    // Reset mid-count, then resume
    repeat (5) step(0, 1, 2'b01, 8'h00, 8'h00);
    chk("up_to_5", 32'(q0), 32'd5);
    step(1, 1, 2'b01, 8'h00, 8'h00);
    chk("rst_mid", 32'(q0), 32'd0);
    step(0, 1, 2'b01, 8'h00, 8'h00);
    step(0, 1, 2'b01, 8'h00, 8'h00);
    chk("rst_resume", 32'(q0), 32'd2);

    // Toggle A5 three times, then hold with en low
    step(1, 0, 2'b00, 8'h00, 8'h00);
    step(0, 1, 2'b00, 8'hA5, 8'h00);
    chk("tog_a5", 32'(q0), 32'hA5);
    chk("tog_qb_5a", 32'(qb0), 32'h5A);
    step(0, 1, 2'b00, 8'hA5, 8'h00);
    chk("tog_00", 32'(q0), 32'h00);
    step(0, 1, 2'b00, 8'hA5, 8'h00);
    step(0, 0, 2'b00, 8'hA5, 8'h00);
    chk("tog_hold", 32'(q0), 32'hA5);

    // Up count across the end of range
    step(1, 0, 2'b00, 8'h00, 8'h00);
    repeat (10) step(0, 1, 2'b01, 8'h00, 8'h00);
    chk("up_wrap", 32'(w0), 32'd1);
    chk("up_sat", 32'(q1), 32'd9);
    repeat (2) step(0, 1, 2'b01, 8'h00, 8'h00);

    // Down count from 1 across zero
    step(0, 1, 2'b11, 8'h00, 8'd1);
    step(0, 1, 2'b10, 8'h00, 8'h00);
    repeat (3) step(0, 1, 2'b10, 8'h00, 8'h00);

    // Out-of-range recovery after load
    step(0, 1, 2'b11, 8'h00, 8'd200);
    chk("load_200", 32'(q0), 32'd200);
    step(0, 1, 2'b01, 8'h00, 8'h00);
    step(0, 1, 2'b11, 8'h00, 8'd200);
    step(0, 1, 2'b10, 8'h00, 8'h00);
    chk("oor_down", 32'(q0), 32'd9);

    // Full-range 4-bit counter wrap from 15
    step(0, 1, 2'b11, 8'h00, 8'd15);
    step(0, 1, 2'b01, 8'h00, 8'h00);
    chk("full_wrap", 32'(w2), 32'd1);
    step(0, 1, 2'b01, 8'h00, 8'h00);

    // Mixed random traffic
    for (int k = 0; k < 60; k++) begin
      step(($urandom_range(15) == 0), ($urandom_range(7) != 0),
           2'($urandom_range(3)), 8'($urandom_range(255)), 8'($urandom_range(255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
